// File: rtl/gb_rtc_backup_seq_pkg.sv
// Shared types, constants and word helpers for the RTC backup sequencer.
package gb_rtc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LD_WAIT   = 3'd1,
        ST_LD_WR     = 3'd2,
        ST_LD_GAP    = 3'd3,
        ST_LD_COMMIT = 3'd4,
        ST_SV_SNAP   = 3'd5,
        ST_SV_EMIT   = 3'd6,
        ST_FIN       = 3'd7
    } rtc_seq_state_e;

    // Mapper address whose write latches the staged RTC words.
    localparam logic [16:0] BK_RTC_COMMIT_ADDR = 17'd4;
    // Savedtime is only meaningful in its low 29 bits.
    localparam int SAVEDTIME_VALID_BITS = 29;
    localparam int SAVEDTIME_HI_LSB     = 16;

    // True when the upper savedtime word carries no bits above the valid range.
    function automatic logic savedtime_hi_ok(input logic [15:0] word);
        logic [15:0] mask_v;
        mask_v = 16'hFFFF << (SAVEDTIME_VALID_BITS - SAVEDTIME_HI_LSB);
        return ((word & mask_v) == 16'h0000);
    endfunction

    // Selects save word idx from the snapshot: ts lo, ts hi, saved lo, saved hi.
    function automatic logic [15:0] sv_word_sel(input logic [31:0] ts,
                                                input logic [31:0] saved,
                                                input logic [1:0]  idx);
        logic [15:0] word_v;
        case (idx)
            2'd0:    word_v = ts[15:0];
            2'd1:    word_v = ts[31:16];
            2'd2:    word_v = saved[15:0];
            2'd3:    word_v = saved[31:16];
            default: word_v = 16'h0000;
        endcase
        return word_v;
    endfunction

endpackage

// File: rtl/gb_rtc_backup_seq_if.sv
// Host save-file channel: load words in, save words out, plus start pulses.
interface gb_rtc_backup_seq_if;
    logic        ld_start;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        sv_start;
    logic        sv_valid;
    logic [1:0]  sv_addr;
    logic [15:0] sv_data;
    logic        sv_ready;

    // Host side.
    modport master (
        output ld_start, ld_valid, ld_data, sv_start, sv_ready,
        input  ld_ready, sv_valid, sv_addr, sv_data
    );

    // Sequencer side.
    modport slave (
        input  ld_start, ld_valid, ld_data, sv_start, sv_ready,
        output ld_ready, sv_valid, sv_addr, sv_data
    );
endinterface

// File: rtl/gb_rtc_backup_seq.sv
// RTC backup sequencer: loads host words into the MBC3 RTC via bk_rtc_wr and
// streams an atomic snapshot of the mapper RTC back to the host.
module gb_rtc_backup_seq
    import gb_rtc_pkg::*;
#(
    parameter int WR_GAP  = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    gb_rtc_backup_seq_if.slave   host,
    input  logic                 rtc_inuse,
    input  logic [31:0]          rtc_ts,
    input  logic [47:0]          rtc_saved,
    output logic                 bk_rtc_wr,
    output logic [16:0]          bk_addr,
    output logic [15:0]          bk_data,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam logic [15:0] GAP_LAST  = 16'(WR_GAP - 1);
    localparam logic [16:0] TIMEOUT_U = 17'(TIMEOUT);

    rtc_seq_state_e state_r;
    rtc_seq_state_e state_next_s;

    logic [1:0]  idx_r;
    logic [15:0] cnt_r;
    logic [15:0] word_r;
    logic [31:0] snap_ts_r;
    logic [31:0] snap_saved_r;
    logic        ld_ready_r;
    logic        sv_valid_r;
    logic [1:0]  sv_addr_r;
    logic [15:0] sv_data_r;
    logic        bk_rtc_wr_r;
    logic [16:0] bk_addr_r;
    logic [15:0] bk_data_r;
    logic        busy_r;
    logic        done_r;
    logic        error_r;

    logic ld_hs_s;
    logic sv_hs_s;
    logic tmo_hit_s;
    logic gap_hit_s;
    logic last_word_s;
    logic ld_word_ok_s;

    assign ld_hs_s      = ld_ready_r & host.ld_valid;
    assign sv_hs_s      = sv_valid_r & host.sv_ready;
    assign tmo_hit_s    = ({1'b0, cnt_r} + 17'd1) >= TIMEOUT_U;
    assign gap_hit_s    = (cnt_r == GAP_LAST);
    assign last_word_s  = (idx_r == 2'd3);
    // Only the final word is range-checked; it is the savedtime upper half.
    assign ld_word_ok_s = !last_word_s || savedtime_hi_ok(host.ld_data);

    assign host.ld_ready = ld_ready_r;
    assign host.sv_valid = sv_valid_r;
    assign host.sv_addr  = sv_addr_r;
    assign host.sv_data  = sv_data_r;
    assign bk_rtc_wr     = bk_rtc_wr_r;
    assign bk_addr       = bk_addr_r;
    assign bk_data       = bk_data_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign error         = error_r;

    // State register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; a start seen while busy is simply not looked at.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (host.ld_start) begin
                    state_next_s = ST_LD_WAIT;
                end else if (host.sv_start) begin
                    state_next_s = ST_SV_SNAP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LD_WAIT: begin
                if (ld_hs_s) begin
                    state_next_s = ST_LD_WR;
                end else if (tmo_hit_s) begin
                    state_next_s = ST_FIN;
                end else begin
                    state_next_s = ST_LD_WAIT;
                end
            end
            ST_LD_WR: begin
                if (last_word_s && !savedtime_hi_ok(word_r)) begin
                    state_next_s = ST_FIN;
                end else if (WR_GAP != 0) begin
                    state_next_s = ST_LD_GAP;
                end else if (last_word_s) begin
                    state_next_s = ST_LD_COMMIT;
                end else begin
                    state_next_s = ST_LD_WAIT;
                end
            end
            ST_LD_GAP: begin
                if (!gap_hit_s) begin
                    state_next_s = ST_LD_GAP;
                end else if (last_word_s) begin
                    state_next_s = ST_LD_COMMIT;
                end else begin
                    state_next_s = ST_LD_WAIT;
                end
            end
            ST_LD_COMMIT: state_next_s = ST_FIN;
            ST_SV_SNAP: begin
                if (rtc_inuse) begin
                    state_next_s = ST_SV_EMIT;
                end else begin
                    state_next_s = ST_FIN;
                end
            end
            ST_SV_EMIT: begin
                if (sv_hs_s && last_word_s) begin
                    state_next_s = ST_FIN;
                end else begin
                    state_next_s = ST_SV_EMIT;
                end
            end
            ST_FIN:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Word index shared by load and save; advances only once a word is finished.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            idx_r <= 2'd0;
        end else if (state_r == ST_IDLE) begin
            idx_r <= 2'd0;
        end else if ((state_r == ST_LD_WR || state_r == ST_LD_GAP) &&
                     state_next_s == ST_LD_WAIT) begin
            idx_r <= idx_r + 2'd1;
        end else if (state_r == ST_SV_EMIT && sv_hs_s && !last_word_s) begin
            idx_r <= idx_r + 2'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Gap/timeout counter: restarts on entry to LD_WAIT or LD_GAP.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt_r <= 16'd0;
        end else if (state_next_s != state_r &&
                     (state_next_s == ST_LD_WAIT || state_next_s == ST_LD_GAP)) begin
            cnt_r <= 16'd0;
        end else if (state_r == ST_LD_WAIT || state_r == ST_LD_GAP) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Load datapath: latch host word and drive the mapper write strobe.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            word_r      <= 16'h0000;
            ld_ready_r  <= 1'b0;
            bk_rtc_wr_r <= 1'b0;
            bk_addr_r   <= 17'd0;
            bk_data_r   <= 16'h0000;
        end else begin
            ld_ready_r  <= (state_next_s == ST_LD_WAIT);
            bk_rtc_wr_r <= 1'b0;
            bk_addr_r   <= 17'd0;
            bk_data_r   <= 16'h0000;
            if (state_r == ST_LD_WAIT && ld_hs_s) begin
                word_r <= host.ld_data;
                // A bad upper savedtime word never reaches the mapper.
                if (ld_word_ok_s) begin
                    bk_rtc_wr_r <= 1'b1;
                    bk_addr_r   <= {15'd0, idx_r};
                    bk_data_r   <= host.ld_data;
                end else begin
                    bk_rtc_wr_r <= 1'b0;
                end
            end else if (state_next_s == ST_LD_COMMIT) begin
                bk_rtc_wr_r <= 1'b1;
                bk_addr_r   <= BK_RTC_COMMIT_ADDR;
                bk_data_r   <= 16'h0000;
            end else begin
                word_r <= word_r;
            end
        end
    end

    // Save datapath: one-cycle snapshot, then hold each word until accepted.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            snap_ts_r    <= 32'd0;
            snap_saved_r <= 32'd0;
            sv_valid_r   <= 1'b0;
            sv_addr_r    <= 2'd0;
            sv_data_r    <= 16'h0000;
        end else if (state_r == ST_SV_SNAP && rtc_inuse) begin
            snap_ts_r    <= rtc_ts;
            snap_saved_r <= rtc_saved[31:0];
            sv_valid_r   <= 1'b1;
            sv_addr_r    <= 2'd0;
            sv_data_r    <= rtc_ts[15:0];
        end else if (state_r == ST_SV_EMIT && sv_hs_s) begin
            if (last_word_s) begin
                sv_valid_r <= 1'b0;
                sv_addr_r  <= 2'd0;
                sv_data_r  <= 16'h0000;
            end else begin
                sv_valid_r <= 1'b1;
                sv_addr_r  <= idx_r + 2'd1;
                sv_data_r  <= sv_word_sel(snap_ts_r, snap_saved_r, idx_r + 2'd1);
            end
        end else begin
            sv_valid_r <= sv_valid_r;
        end
    end

    // Status flags: busy outside IDLE/FIN, done on FIN, sticky abort flag.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE) && (state_next_s != ST_FIN);
            done_r <= (state_next_s == ST_FIN);
            if (state_r == ST_IDLE && state_next_s != ST_IDLE) begin
                error_r <= 1'b0;
            end else if (state_next_s == ST_FIN &&
                         (state_r == ST_LD_WAIT || state_r == ST_LD_WR)) begin
                error_r <= 1'b1;
            end else begin
                error_r <= error_r;
            end
        end
    end

endmodule

// File: tb/tb_gb_rtc_backup_seq.sv
// Directed bench for gb_rtc_backup_seq (WR_GAP=2, TIMEOUT=16).
module tb_gb_rtc_backup_seq;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        rtc_inuse;
    logic [31:0] rtc_ts;
    logic [47:0] rtc_saved;
    logic        bk_rtc_wr;
    logic [16:0] bk_addr;
    logic [15:0] bk_data;
    logic        busy;
    logic        done;
    logic        error;

    gb_rtc_backup_seq_if bus();

    gb_rtc_backup_seq #(.WR_GAP(2), .TIMEOUT(16)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .host      (bus),
        .rtc_inuse (rtc_inuse),
        .rtc_ts    (rtc_ts),
        .rtc_saved (rtc_saved),
        .bk_rtc_wr (bk_rtc_wr),
        .bk_addr   (bk_addr),
        .bk_data   (bk_data),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;

    logic [16:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic [17:0] sv_q[$];
    int          sv_valid_cnt = 0;

    // Record mapper writes and accepted save words mid-cycle.
    always @(negedge clk_sys) begin
        if (bk_rtc_wr) begin
            wr_addr_q.push_back(bk_addr);
            wr_data_q.push_back(bk_data);
        end
        if (bus.sv_valid) begin
            sv_valid_cnt++;
            if (bus.sv_ready) sv_q.push_back({bus.sv_addr, bus.sv_data});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        sv_q.delete();
        sv_valid_cnt = 0;
    endtask

    // Runs one load; nwords words are offered back-to-back, then ld_valid drops.
    task automatic run_load(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3,
                            input int nwords, input logic also_sv,
                            output int done_at, output logic busy_at_done);
        logic [15:0] w[4];
        int   n;
        logic hs_prev;
        w = '{w0, w1, w2, w3};
        n = 0;
        hs_prev = 1'b0;
        done_at = -1;
        busy_at_done = 1'b1;
        @(posedge clk_sys); #1;
        bus.ld_start = 1'b1;
        bus.sv_start = also_sv;
        bus.ld_valid = 1'b1;
        bus.ld_data  = w[0];
        for (int k = 1; k <= 80 && done_at < 0; k++) begin
            @(posedge clk_sys); #1;
            bus.ld_start = 1'b0;
            bus.sv_start = also_sv && (k == 5);
            if (hs_prev) begin
                n++;
                if (n < nwords) begin
                    bus.ld_data = w[n];
                end else begin
                    bus.ld_valid = 1'b0;
                    bus.ld_data  = 16'h0000;
                end
            end
            @(negedge clk_sys);
            if (done) begin
                done_at = k;
                busy_at_done = busy;
            end
            hs_prev = bus.ld_ready && bus.ld_valid;
        end
        bus.ld_valid = 1'b0;
        bus.sv_start = 1'b0;
    endtask

    // Runs one save; checks every presented word against the expected table.
    task automatic run_save(input logic inuse, input logic toggle, input logic change,
                            output int done_at);
        logic [15:0] exp_w[4];
        int exp_idx;
        exp_w = '{16'hBEEF, 16'hDEAD, 16'h789A, 16'h3456};
        exp_idx = 0;
        done_at = -1;
        rtc_inuse = inuse;
        rtc_ts    = 32'hDEADBEEF;
        rtc_saved = 48'h0012_3456_789A;
        @(posedge clk_sys); #1;
        bus.sv_start = 1'b1;
        bus.sv_ready = !toggle;
        for (int k = 1; k <= 80 && done_at < 0; k++) begin
            @(posedge clk_sys); #1;
            bus.sv_start = 1'b0;
            if (toggle) bus.sv_ready = (k % 2 == 0);
            if (change && k == 2) begin
                rtc_ts    = 32'h0000_0000;
                rtc_saved = 48'hFFFF_FFFF_FFFF;
            end
            @(negedge clk_sys);
            if (done) done_at = k;
            if (bus.sv_valid && exp_idx < 4) begin
                chk("sv_addr", bus.sv_addr, exp_idx[1:0]);
                chk("sv_data", bus.sv_data, exp_w[exp_idx]);
                if (bus.sv_ready) exp_idx++;
            end
        end
        bus.sv_ready = 1'b0;
    endtask

    initial begin
        int          d;
        logic        b;
        logic [16:0] exp_a[5];
        logic [15:0] exp_d[5];
        logic [17:0] exp_s[4];

        reset = 1'b1;
        rtc_inuse = 1'b0;
        rtc_ts = 32'd0;
        rtc_saved = 48'd0;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = 16'h0000;
        bus.sv_start = 1'b0;
        bus.sv_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_wr", bk_rtc_wr, 1'b0);
        chk("rst_ld_ready", bus.ld_ready, 1'b0);
        chk("rst_sv_valid", bus.sv_valid, 1'b0);
        reset = 1'b0;
        repeat (2) @(posedge clk_sys);

        // Normal load: four strobes then commit at addr 4
        clear_mon();
        run_load(16'h1234, 16'h5678, 16'h0ABC, 16'h0001, 4, 1'b0, d, b);
        chk("ld_done_cycle", d, 18);
        chk("ld_busy_at_done", b, 1'b0);
        chk("ld_error", error, 1'b0);
        chk("ld_wr_count", wr_addr_q.size(), 5);
        exp_a = '{17'd0, 17'd1, 17'd2, 17'd3, 17'd4};
        exp_d = '{16'h1234, 16'h5678, 16'h0ABC, 16'h0001, 16'h0000};
        for (int i = 0; i < 5 && i < wr_addr_q.size(); i++) begin
            chk("ld_wr_addr", wr_addr_q[i], exp_a[i]);
            chk("ld_wr_data", wr_data_q[i], exp_d[i]);
        end

        // Validation: bad savedtime hi word suppresses write and commit
        clear_mon();
        run_load(16'h1111, 16'h2222, 16'h3333, 16'hE000, 4, 1'b0, d, b);
        chk("val_done_cycle", d, 15);
        chk("val_error", error, 1'b1);
        chk("val_wr_count", wr_addr_q.size(), 3);
        for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
            chk("val_wr_addr", wr_addr_q[i], 17'(i));
        end

        // Timeout: only one word offered
        clear_mon();
        run_load(16'h0042, 16'h0000, 16'h0000, 16'h0000, 1, 1'b0, d, b);
        chk("tmo_done_cycle", d, 21);
        chk("tmo_error", error, 1'b1);
        chk("tmo_wr_count", wr_addr_q.size(), 1);

        // Save with RTC not in use: no words, error cleared
        clear_mon();
        run_save(1'b0, 1'b0, 1'b0, d);
        chk("sv0_done_cycle", d, 2);
        chk("sv0_valid_cnt", sv_valid_cnt, 0);
        chk("sv0_error", error, 1'b0);

        // Save with sv_ready held high
        clear_mon();
        run_save(1'b1, 1'b0, 1'b0, d);
        chk("sv_done_cycle", d, 6);
        chk("sv_word_count", sv_q.size(), 4);

        // Save with stalls and mapper values changing after the snapshot
        clear_mon();
        run_save(1'b1, 1'b1, 1'b1, d);
        chk("svs_done_seen", d > 0, 1'b1);
        chk("svs_word_count", sv_q.size(), 4);
        exp_s = '{{2'd0, 16'hBEEF}, {2'd1, 16'hDEAD}, {2'd2, 16'h789A}, {2'd3, 16'h3456}};
        for (int i = 0; i < 4 && i < sv_q.size(); i++) begin
            chk("svs_word", sv_q[i], exp_s[i]);
        end

        // ld_start and sv_start together: load only; mid-load sv_start ignored
        clear_mon();
        run_load(16'h1234, 16'h5678, 16'h0ABC, 16'h0001, 4, 1'b1, d, b);
        chk("both_done_cycle", d, 18);
        chk("both_wr_count", wr_addr_q.size(), 5);
        repeat (10) @(posedge clk_sys);
        #1;
        chk("both_no_save", sv_valid_cnt, 0);
        chk("both_idle", busy, 1'b0);

        // Reset asserted while in LD_GAP
        clear_mon();
        @(posedge clk_sys); #1;
        bus.ld_start = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'h1234;
        @(posedge clk_sys); #1;
        bus.ld_start = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        chk("gap_busy_before", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_wr", bk_rtc_wr, 1'b0);
        chk("arst_ld_ready", bus.ld_ready, 1'b0);
        chk("arst_addr", bk_addr, 17'd0);
        clear_mon();
        repeat (2) @(posedge clk_sys);
        #1;
        reset = 1'b0;
        repeat (40) @(posedge clk_sys);
        #1;
        chk("arst_no_strobe", wr_addr_q.size(), 0);
        chk("arst_idle", busy, 1'b0);
        bus.ld_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
